// File: rtl/order_book_levels_pkg.sv
// Shared types and helpers for the aggregated per-price-level order book.
package order_book_levels_pkg;

    localparam int unsigned BOOK_PRICE_W  = 32;
    localparam int unsigned BOOK_SHARES_W = 32;
    localparam int unsigned LOCATE_W      = 16;

    // One price level, also reused as the add/reduce request payload.
    typedef struct packed {
        logic                     valid;
        logic [BOOK_PRICE_W-1:0]  price;
        logic [BOOK_SHARES_W-1:0] shares;
    } bookLevelType;

    // Share addition that clamps at all-ones instead of wrapping.
    function automatic logic [BOOK_SHARES_W-1:0] satAddShares(
        input logic [BOOK_SHARES_W-1:0] a,
        input logic [BOOK_SHARES_W-1:0] b
    );
        logic [BOOK_SHARES_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[BOOK_SHARES_W] ? '1 : sum[BOOK_SHARES_W-1:0];
    endfunction

endpackage

// File: rtl/order_book_levels_book_side.sv
// One side of the book: slot array, match/free encoders, update logic and
// the registered best-level reduction (max price for bids, min for asks).
module book_side
    import order_book_levels_pkg::*;
#(
    parameter int unsigned LEVELS = 16,
    parameter bit          IS_BID = 1'b1
) (
    input  logic         clkIn,
    input  logic         rstIn,
    input  bookLevelType addReq,
    input  bookLevelType reduceReq,
    output bookLevelType bestLevel,
    output bookLevelType bestLevelC,
    output logic         overflow,
    output logic         underflow
);

    localparam int unsigned IDX_W = $clog2(LEVELS);

    bookLevelType slots     [LEVELS];
    bookLevelType slotsNext [LEVELS];

    logic             addHit;
    logic             redHit;
    logic             freeHit;
    logic [IDX_W-1:0] addIdx;
    logic [IDX_W-1:0] redIdx;
    logic [IDX_W-1:0] freeIdx;
    logic             overflowNext;
    logic             underflowNext;

    // Priority encoders over the current slots; the lowest index wins.
    always_comb begin
        addHit  = 1'b0;
        redHit  = 1'b0;
        freeHit = 1'b0;
        addIdx  = '0;
        redIdx  = '0;
        freeIdx = '0;
        for (int i = int'(LEVELS) - 1; i >= 0; i--) begin
            if (slots[i].valid && (slots[i].price == addReq.price)) begin
                addHit = 1'b1;
                addIdx = IDX_W'(i);
            end
            if (slots[i].valid && (slots[i].price == reduceReq.price)) begin
                redHit = 1'b1;
                redIdx = IDX_W'(i);
            end
            if (!slots[i].valid) begin
                freeHit = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    // Read-modify-write of the slot array: reduce first, then the add on top.
    // Free-slot choice uses pre-reduce occupancy, so a slot emptied this cycle
    // is never reused by a different-price add in the same cycle.
    always_comb begin
        slotsNext     = slots;
        overflowNext  = 1'b0;
        underflowNext = 1'b0;

        if (reduceReq.valid) begin
            if (!redHit) begin
                underflowNext = 1'b1;
            end else begin
                if (reduceReq.shares > slots[redIdx].shares) begin
                    underflowNext = 1'b1;
                end
                if (reduceReq.shares < slots[redIdx].shares) begin
                    slotsNext[redIdx].shares = slots[redIdx].shares - reduceReq.shares;
                end else begin
                    slotsNext[redIdx] = '0;
                end
            end
        end

        if (addReq.valid) begin
            if (addHit) begin
                // Same-price reduce already folded into slotsNext; re-validate on top.
                slotsNext[addIdx].valid  = 1'b1;
                slotsNext[addIdx].price  = addReq.price;
                slotsNext[addIdx].shares = satAddShares(slotsNext[addIdx].shares, addReq.shares);
            end else if (freeHit) begin
                slotsNext[freeIdx].valid  = 1'b1;
                slotsNext[freeIdx].price  = addReq.price;
                slotsNext[freeIdx].shares = addReq.shares;
            end else begin
                overflowNext = 1'b1;
            end
        end
    end

    // Best-level reduction over the committed slots; empty side yields all zeros.
    always_comb begin
        bestLevelC = '0;
        for (int i = 0; i < int'(LEVELS); i++) begin
            if (slots[i].valid) begin
                if (!bestLevelC.valid) begin
                    bestLevelC = slots[i];
                end else if (IS_BID ? (slots[i].price > bestLevelC.price)
                                    : (slots[i].price < bestLevelC.price)) begin
                    bestLevelC = slots[i];
                end
            end
        end
    end

    // Slot array, per-side flags and the registered best level.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            for (int i = 0; i < int'(LEVELS); i++) begin
                slots[i] <= '0;
            end
            bestLevel <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < int'(LEVELS); i++) begin
                slots[i] <= slotsNext[i];
            end
            bestLevel <= bestLevelC;
            overflow  <= overflowNext;
            underflow <= underflowNext;
        end
    end

endmodule

// File: rtl/order_book_levels.sv
// Aggregated per-price-level book for one instrument: locate filter, side
// steering, two book_side instances, flag outputs and change detection.
module order_book_levels
    import order_book_levels_pkg::*;
#(
    parameter int unsigned         LEVELS       = 16,
    parameter logic [LOCATE_W-1:0] STOCK_LOCATE = 16'h0001
) (
    input  logic                     clkIn,
    input  logic                     rstIn,
    input  logic                     addValidIn,
    input  logic [LOCATE_W-1:0]      addLocateIn,
    input  logic [BOOK_PRICE_W-1:0]  addPriceIn,
    input  logic [BOOK_SHARES_W-1:0] addSharesIn,
    input  logic                     addBuySellIn,
    input  logic                     delExecValidIn,
    input  logic [LOCATE_W-1:0]      locateIn,
    input  logic [BOOK_PRICE_W-1:0]  priceIn,
    input  logic [BOOK_SHARES_W-1:0] sharesIn,
    input  logic                     buySellIn,
    output logic                     bestBidValidOut,
    output logic [BOOK_PRICE_W-1:0]  bestBidPriceOut,
    output logic [BOOK_SHARES_W-1:0] bestBidSharesOut,
    output logic                     bestAskValidOut,
    output logic [BOOK_PRICE_W-1:0]  bestAskPriceOut,
    output logic [BOOK_SHARES_W-1:0] bestAskSharesOut,
    output logic                     bookUpdateOut,
    output logic                     overflowOut,
    output logic                     underflowOut
);

    logic         addAcceptC;
    logic         redAcceptC;
    bookLevelType bidAddC;
    bookLevelType askAddC;
    bookLevelType bidRedC;
    bookLevelType askRedC;

    bookLevelType bidAddReq;
    bookLevelType askAddReq;
    bookLevelType bidRedReq;
    bookLevelType askRedReq;

    bookLevelType bidBest;
    bookLevelType askBest;
    bookLevelType bidBestC;
    bookLevelType askBestC;
    logic         bidOverflow;
    logic         askOverflow;
    logic         bidUnderflow;
    logic         askUnderflow;

    // Locate filter and side steering; zero-share adds are dropped here.
    always_comb begin
        addAcceptC = addValidIn && (addLocateIn == STOCK_LOCATE) && (addSharesIn != '0);
        redAcceptC = delExecValidIn && (locateIn == STOCK_LOCATE);

        bidAddC        = '0;
        askAddC        = '0;
        bidRedC        = '0;
        askRedC        = '0;

        bidAddC.valid  = addAcceptC && addBuySellIn;
        bidAddC.price  = addPriceIn;
        bidAddC.shares = addSharesIn;
        askAddC.valid  = addAcceptC && !addBuySellIn;
        askAddC.price  = addPriceIn;
        askAddC.shares = addSharesIn;

        bidRedC.valid  = redAcceptC && buySellIn;
        bidRedC.price  = priceIn;
        bidRedC.shares = sharesIn;
        askRedC.valid  = redAcceptC && !buySellIn;
        askRedC.price  = priceIn;
        askRedC.shares = sharesIn;
    end

    // Input capture stage; strobes seen during reset are discarded.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            bidAddReq <= '0;
            askAddReq <= '0;
            bidRedReq <= '0;
            askRedReq <= '0;
        end else begin
            bidAddReq <= bidAddC;
            askAddReq <= askAddC;
            bidRedReq <= bidRedC;
            askRedReq <= askRedC;
        end
    end

    book_side #(
        .LEVELS (LEVELS),
        .IS_BID (1'b1)
    ) u_bidSide (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .addReq     (bidAddReq),
        .reduceReq  (bidRedReq),
        .bestLevel  (bidBest),
        .bestLevelC (bidBestC),
        .overflow   (bidOverflow),
        .underflow  (bidUnderflow)
    );

    book_side #(
        .LEVELS (LEVELS),
        .IS_BID (1'b0)
    ) u_askSide (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .addReq     (askAddReq),
        .reduceReq  (askRedReq),
        .bestLevel  (askBest),
        .bestLevelC (askBestC),
        .overflow   (askOverflow),
        .underflow  (askUnderflow)
    );

    // Flag pulses aligned with the best-of-book outputs, plus change detect.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            overflowOut   <= 1'b0;
            underflowOut  <= 1'b0;
            bookUpdateOut <= 1'b0;
        end else begin
            overflowOut   <= bidOverflow | askOverflow;
            underflowOut  <= bidUnderflow | askUnderflow;
            bookUpdateOut <= (bidBestC != bidBest) || (askBestC != askBest);
        end
    end

    assign bestBidValidOut  = bidBest.valid;
    assign bestBidPriceOut  = bidBest.price;
    assign bestBidSharesOut = bidBest.shares;
    assign bestAskValidOut  = askBest.valid;
    assign bestAskPriceOut  = askBest.price;
    assign bestAskSharesOut = askBest.shares;

endmodule
